// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexing scheduler for a shared 7-segment display.
//               The scheduler advances on the single-cycle scan pulse from the
//               clock divider. It drives one digit at a time, round-robin, and
//               inserts a one-cycle blanking gap before each digit so no
//               ghosting occurs. Display data is double-buffered and is
//               committed only at frame boundaries.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               tick           - scan pulse, one clk wide
//               en             - scan enable (0 = display dark)
//               load           - capture data_in/dp_in into pending buffer
//               data_in        - 4*NUM_DIGITS hex nibbles, nibble i -> digit i
//               dp_in          - decimal point per digit
//               an             - registered digit anode selects
//               seg            - registered segments {g,f,e,d,c,b,a}
//               dp             - registered decimal point of driven digit
//               frame_done     - one-cycle pulse when index wraps to 0
// Option      : `define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros
//               (digit 0 is never blanked; anode timing is unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int                IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic              c_INV      = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_wrap;
    logic                    w_commit;

    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_valid;

    logic [3:0]              w_nibble;
    logic                    w_dp_bit;
    logic [6:0]              w_seg_dec;
    logic                    w_lz_blank;

    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [6:0]              w_seg_nxt;
    logic                    w_dp_nxt;

    // ------------------------------------------------------------------------
    // Next-state logic. en=0 overrides everything and parks the scan at
    // digit 0. A commit happens on leaving IDLE (so the first frame shows the
    // latest data) and on the wrap tick.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wrap      = 1'b0;
        w_commit    = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_BLANK;
                    w_idx_nxt   = '0;
                    w_commit    = 1'b1;
                end
                ST_BLANK: begin
                    w_state_nxt = ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (tick) begin
                        w_state_nxt = ST_BLANK;
                        if (r_idx == c_LAST_IDX) begin
                            w_idx_nxt = '0;
                            w_wrap    = 1'b1;
                            w_commit  = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Select the nibble/dp of the current digit. A compare-based mux keeps
    // the selection in range when NUM_DIGITS is not a power of two.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nibble = 4'h0;
        w_dp_bit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble = r_act_data[4*i +: 4];
                w_dp_bit = r_act_dp[i];
            end
        end
    end

    // Hex decode, active-high, bit order {g,f,e,d,c,b,a}; lowercase b and d.
    always_comb begin
        w_seg_dec = 7'h00;
        case (w_nibble)
            4'h0: w_seg_dec = 7'h3F;
            4'h1: w_seg_dec = 7'h06;
            4'h2: w_seg_dec = 7'h5B;
            4'h3: w_seg_dec = 7'h4F;
            4'h4: w_seg_dec = 7'h66;
            4'h5: w_seg_dec = 7'h6D;
            4'h6: w_seg_dec = 7'h7D;
            4'h7: w_seg_dec = 7'h07;
            4'h8: w_seg_dec = 7'h7F;
            4'h9: w_seg_dec = 7'h6F;
            4'hA: w_seg_dec = 7'h77;
            4'hB: w_seg_dec = 7'h7C;
            4'hC: w_seg_dec = 7'h39;
            4'hD: w_seg_dec = 7'h5E;
            4'hE: w_seg_dec = 7'h79;
            4'hF: w_seg_dec = 7'h71;
            default: w_seg_dec = 7'h00;
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // w_lz_mask[i] is set when nibbles and dp bits i..NUM_DIGITS-1 are all
    // zero, i.e. digit i is a leading zero. Digit 0 is never blanked.
    logic [NUM_DIGITS-1:0] w_lz_mask;

    always_comb begin
        logic v_run;
        v_run     = 1'b1;
        w_lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_run        = v_run & (r_act_data[4*i +: 4] == 4'h0) & ~r_act_dp[i];
            w_lz_mask[i] = v_run;
        end
    end

    always_comb begin
        w_lz_blank = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_lz_blank = w_lz_mask[i];
            end
        end
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Output values for the next cycle, active-high. Outputs are only lit
    // when the next state is DRIVE; the index does not change on entry to or
    // while holding DRIVE, so r_idx selects the correct digit.
    // ------------------------------------------------------------------------
    always_comb begin
        w_an_nxt  = '0;
        w_seg_nxt = 7'h00;
        w_dp_nxt  = 1'b0;
        if (w_state_nxt == ST_DRIVE) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_idx_nxt == IDX_W'(i)) begin
                    w_an_nxt[i] = 1'b1;
                end
            end
            w_seg_nxt = w_lz_blank ? 7'h00 : w_seg_dec;
            w_dp_nxt  = w_dp_bit;
        end
    end

    // ------------------------------------------------------------------------
    // State, buffers and output registers. Polarity inversion is applied
    // only here. A load coinciding with a commit goes straight to the active
    // buffer, so pending_valid stays clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            an           <= {NUM_DIGITS{c_INV}};
            seg          <= {7{c_INV}};
            dp           <= c_INV;
            frame_done   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            an         <= w_an_nxt ^ {NUM_DIGITS{c_INV}};
            seg        <= w_seg_nxt ^ {7{c_INV}};
            dp         <= w_dp_nxt ^ c_INV;
            frame_done <= w_wrap;
            if (w_commit) begin
                if (load) begin
                    r_act_data <= data_in;
                    r_act_dp   <= dp_in;
                end else if (r_pend_valid) begin
                    r_act_data <= r_pend_data;
                    r_act_dp   <= r_pend_dp;
                end
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend_data  <= data_in;
                r_pend_dp    <= dp_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Directed self-checking bench for seg7_scan_ctrl with
//               NUM_DIGITS=8, ACTIVE_LOW=1. Expected segment patterns come
//               from a hand-written hex table in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit c_LZ = 1'b1;
`else
    localparam bit c_LZ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        tick;
    logic        en;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks;
    int errors;

    seg7_scan_ctrl #(
        .NUM_DIGITS (8),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low segment pattern for a hex digit.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] hi;
        case (n)
            4'h0: hi = 7'h3F;  4'h1: hi = 7'h06;  4'h2: hi = 7'h5B;  4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66;  4'h5: hi = 7'h6D;  4'h6: hi = 7'h7D;  4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F;  4'h9: hi = 7'h6F;  4'hA: hi = 7'h77;  4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39;  4'hD: hi = 7'h5E;  4'hE: hi = 7'h79;  default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] d, input int i);
        return d[4*i +: 4];
    endfunction

    function automatic logic [7:0] an_of(input int i);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From DRIVE of digit k: hold two cycles, tick, BLANK, arrive at DRIVE k+1.
    task automatic advance();
        repeat (2) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; tick = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
        repeat (3) step();
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: an=%h seg=%h dp=%b fd=%b required an=ff seg=7f dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
        rst = 1'b0; en = 1'b0; tick = 1'b0;
        step();
        checks++;
        if (an !== 8'hFF || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: an=%h fd=%b required an=ff fd=0", an, frame_done);
        end
    endtask

    task automatic test_full_scan();
        logic [31:0] d;
        logic [6:0]  exp_seg;
        d = 32'h0123_4567;
        load = 1'b1; data_in = d; dp_in = 8'h00;
        step();
        load = 1'b0;
        en = 1'b1;
        step();
        checks++;
        if (an !== 8'hFF) begin
            errors++;
            $display("FAIL scan_first_blank: an=%h required ff", an);
        end
        step();
        for (int k = 0; k < 8; k++) begin
            exp_seg = (c_LZ && k == 7) ? 7'h7F : seg_of(nib(d, k));
            checks++;
            if (an !== an_of(k) || seg !== exp_seg || dp !== 1'b1 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL scan_digit%0d: an=%h seg=%h dp=%b fd=%b required an=%h seg=%h dp=1 fd=0",
                         k, an, seg, dp, frame_done, an_of(k), exp_seg);
            end
            repeat (3) step();
            checks++;
            if (an !== an_of(k)) begin
                errors++;
                $display("FAIL scan_hold%0d: an=%h required %h", k, an, an_of(k));
            end
            tick = 1'b1;
            step();
            tick = 1'b0;
            checks++;
            if (an !== 8'hFF || frame_done !== (k == 7)) begin
                errors++;
                $display("FAIL scan_blank%0d: an=%h fd=%b required an=ff fd=%b",
                         k, an, frame_done, (k == 7));
            end
            step();
        end
    endtask

    // Starts at DRIVE digit 0 with 0123_4567 active.
    task automatic test_no_tearing();
        logic [6:0] exp_seg;
        repeat (3) advance();
        load = 1'b1; data_in = 32'hFFFF_FFFF; dp_in = 8'h00;
        step();
        load = 1'b0;
        for (int k = 3; k < 8; k++) begin
            exp_seg = (c_LZ && k == 7) ? 7'h7F : seg_of(nib(32'h0123_4567, k));
            checks++;
            if (an !== an_of(k) || seg !== exp_seg) begin
                errors++;
                $display("FAIL tear_old_digit%0d: an=%h seg=%h required an=%h seg=%h",
                         k, an, seg, an_of(k), exp_seg);
            end
            advance();
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (an !== an_of(k) || seg !== 7'h0E) begin
                errors++;
                $display("FAIL tear_new_digit%0d: an=%h seg=%h required an=%h seg=0e",
                         k, an, seg, an_of(k));
            end
            if (k < 7) advance();
        end
    endtask

    // Starts at DRIVE digit 7 with FFFF_FFFF active.
    task automatic test_load_at_wrap();
        repeat (2) step();
        load = 1'b1; data_in = 32'h89AB_CDEF; dp_in = 8'h01; tick = 1'b1;
        step();
        load = 1'b0; dp_in = 8'h00; tick = 1'b0;
        checks++;
        if (an !== 8'hFF || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_blank: an=%h fd=%b required an=ff fd=1", an, frame_done);
        end
        step();
        checks++;
        if (an !== 8'hFE || seg !== 7'h0E || dp !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL wrap_digit0: an=%h seg=%h dp=%b fd=%b required an=fe seg=0e dp=0 fd=0",
                     an, seg, dp, frame_done);
        end
        advance();
        checks++;
        if (an !== 8'hFD || seg !== 7'h06 || dp !== 1'b1) begin
            errors++;
            $display("FAIL wrap_digit1: an=%h seg=%h dp=%b required an=fd seg=06 dp=1", an, seg, dp);
        end
    endtask

    // Starts at DRIVE digit 1 with 89AB_CDEF / dp 01 active.
    task automatic test_disable_mid_scan();
        repeat (4) advance();
        checks++;
        if (an !== 8'hDF || seg !== seg_of(4'hA)) begin
            errors++;
            $display("FAIL dis_digit5: an=%h seg=%h required an=df seg=%h", an, seg, seg_of(4'hA));
        end
        en = 1'b0;
        step();
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL dis_dark: an=%h seg=%h dp=%b fd=%b required an=ff seg=7f dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
        step();
        // tick is high through IDLE and BLANK and must be ignored there
        en = 1'b1; tick = 1'b1;
        step();
        checks++;
        if (an !== 8'hFF) begin
            errors++;
            $display("FAIL dis_reenable_blank: an=%h required ff", an);
        end
        step();
        tick = 1'b0;
        checks++;
        if (an !== 8'hFE || seg !== 7'h0E || dp !== 1'b0) begin
            errors++;
            $display("FAIL dis_restart_digit0: an=%h seg=%h dp=%b required an=fe seg=0e dp=0",
                     an, seg, dp);
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp_seg;
        logic       exp_dp;
        en = 1'b0;
        step();
        load = 1'b1; data_in = 32'h0000_0042; dp_in = 8'h00;
        step();
        load = 1'b0;
        en = 1'b1;
        step();
        step();
        // queue dp_in[5]=1 for the next frame
        load = 1'b1; dp_in = 8'h20;
        step();
        load = 1'b0; dp_in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            exp_seg = (k == 0) ? 7'h24 : (k == 1) ? 7'h19 : (c_LZ ? 7'h7F : 7'h40);
            checks++;
            if (an !== an_of(k) || seg !== exp_seg || dp !== 1'b1) begin
                errors++;
                $display("FAIL lz_frame1_digit%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=1",
                         k, an, seg, dp, an_of(k), exp_seg);
            end
            advance();
        end
        for (int k = 0; k < 8; k++) begin
            exp_seg = (k == 0) ? 7'h24 : (k == 1) ? 7'h19 :
                      (k <= 5) ? 7'h40 : (c_LZ ? 7'h7F : 7'h40);
            exp_dp  = (k == 5) ? 1'b0 : 1'b1;
            checks++;
            if (an !== an_of(k) || seg !== exp_seg || dp !== exp_dp) begin
                errors++;
                $display("FAIL lz_frame2_digit%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         k, an, seg, dp, an_of(k), exp_seg, exp_dp);
            end
            if (k < 7) advance();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b0; tick = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
        #2;
        test_reset();
        test_full_scan();
        test_no_tearing();
        test_load_at_wrap();
        test_disable_mid_scan();
        test_leading_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
